axi_lite_reg_slave: RTL and testbench



---
 rtl/axi_lite_reg_slave_if.sv | 35 +++
 rtl/axi_lite_reg_slave.sv | 165 ++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_slave_if.sv
// AXI-Lite bus bundle with the master and slave views used by the register front end.
interface AXI_LITE #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport Master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport Slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register bank: read/write control registers driven out, read-only status registers in.
module axi_lite_reg_slave #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RW     = 6,
  parameter int unsigned NUM_RO     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  AXI_LITE.Slave                       s_axi,
  output logic [NUM_RW*DATA_WIDTH-1:0] ctrl_q,
  output logic [NUM_RW-1:0]            ctrl_wr,
  input  logic [NUM_RO*DATA_WIDTH-1:0] status_i
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - LSB;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic                              aw_held;
  logic                              w_held;
  logic [IDX_W-1:0]                  aw_idx;
  logic [DATA_WIDTH-1:0]             wdata_q;
  logic [STRB_W-1:0]                 wstrb_q;
  logic [NUM_RW-1:0][DATA_WIDTH-1:0] regs;

  logic                  aw_hs_c;
  logic                  w_hs_c;
  logic                  commit_c;
  logic                  wr_ok_c;
  logic [IDX_W-1:0]      wr_idx_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [STRB_W-1:0]     wr_strb_c;
  logic [IDX_W-1:0]      rd_idx_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  rd_ok_c;
  logic                  unused;

  assign ctrl_q = regs;
  assign unused = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[LSB-1:0], s_axi.araddr[LSB-1:0]};

  // A channel handshaking this cycle supplies its fields directly, otherwise the held copy is used.
  assign aw_hs_c   = s_axi.awvalid && s_axi.awready;
  assign w_hs_c    = s_axi.wvalid && s_axi.wready;
  assign commit_c  = (w_state == W_IDLE) && (aw_held || aw_hs_c) && (w_held || w_hs_c);
  assign wr_idx_c  = aw_hs_c ? s_axi.awaddr[ADDR_WIDTH-1:LSB] : aw_idx;
  assign wr_data_c = w_hs_c ? s_axi.wdata : wdata_q;
  assign wr_strb_c = w_hs_c ? s_axi.wstrb : wstrb_q;
  assign wr_ok_c   = 32'(wr_idx_c) < NUM_RW;
  assign rd_idx_c  = s_axi.araddr[ADDR_WIDTH-1:LSB];

  // Read mux over control registers then status inputs; anything else is a decode error.
  always_comb begin
    rd_data_c = '0;
    rd_ok_c   = 1'b0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (32'(rd_idx_c) == i) begin
        rd_data_c = regs[i];
        rd_ok_c   = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_RO; i++) begin
      if (32'(rd_idx_c) == NUM_RW + i) begin
        rd_data_c = status_i[i*DATA_WIDTH +: DATA_WIDTH];
        rd_ok_c   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      regs          <= '0;
      ctrl_wr       <= '0;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= 2'b00;
    end else begin
      ctrl_wr <= '0;
      case (w_state)
        W_IDLE: begin
          if (aw_hs_c) aw_idx <= s_axi.awaddr[ADDR_WIDTH-1:LSB];
          if (w_hs_c) begin
            wdata_q <= s_axi.wdata;
            wstrb_q <= s_axi.wstrb;
          end
          if (commit_c) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b1;
            s_axi.bresp   <= wr_ok_c ? 2'b00 : 2'b10;
            w_state       <= W_RESP;
            for (int unsigned i = 0; i < NUM_RW; i++) begin
              if (32'(wr_idx_c) == i) begin
                ctrl_wr[i] <= 1'b1;
                for (int unsigned j = 0; j < STRB_W; j++) begin
                  if (wr_strb_c[j]) regs[i][j*8 +: 8] <= wr_data_c[j*8 +: 8];
                end
              end
            end
          end else begin
            aw_held       <= aw_held || aw_hs_c;
            w_held        <= w_held || w_hs_c;
            s_axi.awready <= !(aw_held || aw_hs_c);
            s_axi.wready  <= !(w_held || w_hs_c);
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            s_axi.bvalid  <= 1'b0;
            s_axi.awready <= 1'b1;
            s_axi.wready  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi.arvalid && s_axi.arready) begin
            s_axi.rdata   <= rd_data_c;
            s_axi.rresp   <= rd_ok_c ? 2'b00 : 2'b10;
            s_axi.rvalid  <= 1'b1;
            s_axi.arready <= 1'b0;
            r_state       <= R_RESP;
          end else begin
            s_axi.arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axi.rready) begin
            s_axi.rvalid  <= 1'b0;
            s_axi.arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed scenarios then randomized traffic against an array model.
module tb_axi_lite_reg_slave;
  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned NRW = 6;
  localparam int unsigned NRO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  AXI_LITE #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  logic [NRW*DW-1:0] ctrl_q;
  logic [NRW-1:0]    ctrl_wr;
  logic [NRO*DW-1:0] status_i;

  axi_lite_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RW(NRW), .NUM_RO(NRO)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_axi    (ifc),
    .ctrl_q   (ctrl_q),
    .ctrl_wr  (ctrl_wr),
    .status_i (status_i)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] ctrl_m   [NRW];
  logic [31:0] status_m [NRO];

  always_comb begin
    for (int i = 0; i < int'(NRO); i++) status_i[i*DW +: DW] = status_m[i];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < int'(NRW); i++) chk(tag, 64'(ctrl_q[i*DW +: DW]), 64'(ctrl_m[i]));
  endtask

  // Write with W leading AW by lead cycles (negative: AW leads), then stall bready for stall cycles.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input int stall);
    int          idx;
    int          gap;
    logic [1:0]  eresp;
    logic [5:0]  ewr;
    idx = int'(addr[7:2]);
    gap = (lead < 0) ? -lead : lead;
    chk("awready_idle", 64'(ifc.awready), 64'(1));
    chk("wready_idle", 64'(ifc.wready), 64'(1));
    ifc.awaddr = addr;
    ifc.wdata  = data;
    ifc.wstrb  = strb;
    if (gap == 0) begin
      ifc.awvalid = 1'b1;
      ifc.wvalid  = 1'b1;
      step();
    end else begin
      if (lead > 0) ifc.wvalid = 1'b1;
      else          ifc.awvalid = 1'b1;
      step();
      ifc.awvalid = 1'b0;
      ifc.wvalid  = 1'b0;
      chk("bvalid_early", 64'(ifc.bvalid), 64'(0));
      for (int k = 1; k < gap; k++) begin
        step();
        chk("bvalid_early", 64'(ifc.bvalid), 64'(0));
      end
      if (lead > 0) ifc.awvalid = 1'b1;
      else          ifc.wvalid = 1'b1;
      step();
    end
    ifc.awvalid = 1'b0;
    ifc.wvalid  = 1'b0;
    if (idx < int'(NRW)) begin
      eresp = 2'b00;
      ewr   = 6'(1 << idx);
      for (int j = 0; j < 4; j++) if (strb[j]) ctrl_m[idx][j*8 +: 8] = data[j*8 +: 8];
    end else begin
      eresp = 2'b10;
      ewr   = 6'd0;
    end
    chk("bvalid", 64'(ifc.bvalid), 64'(1));
    chk("bresp", 64'(ifc.bresp), 64'(eresp));
    chk("ctrl_wr_pulse", 64'(ctrl_wr), 64'(ewr));
    check_regs("ctrl_q_after_write");
    for (int k = 0; k < stall; k++) begin
      step();
      chk("bvalid_hold", 64'(ifc.bvalid), 64'(1));
      chk("bresp_hold", 64'(ifc.bresp), 64'(eresp));
      chk("ctrl_wr_once", 64'(ctrl_wr), 64'(0));
    end
    ifc.bready = 1'b1;
    step();
    ifc.bready = 1'b0;
    chk("bvalid_drop", 64'(ifc.bvalid), 64'(0));
    chk("ctrl_wr_clear", 64'(ctrl_wr), 64'(0));
    chk("awready_back", 64'(ifc.awready), 64'(1));
    chk("wready_back", 64'(ifc.wready), 64'(1));
  endtask

  task automatic do_read(input logic [7:0] addr, input int stall);
    int          idx;
    logic [31:0] edata;
    logic [1:0]  eresp;
    idx = int'(addr[7:2]);
    if (idx < int'(NRW)) begin
      edata = ctrl_m[idx];
      eresp = 2'b00;
    end else if (idx < int'(NRW + NRO)) begin
      edata = status_m[idx - int'(NRW)];
      eresp = 2'b00;
    end else begin
      edata = 32'd0;
      eresp = 2'b10;
    end
    chk("arready_idle", 64'(ifc.arready), 64'(1));
    ifc.araddr  = addr;
    ifc.arvalid = 1'b1;
    step();
    ifc.arvalid = 1'b0;
    chk("rvalid", 64'(ifc.rvalid), 64'(1));
    chk("rdata", 64'(ifc.rdata), 64'(edata));
    chk("rresp", 64'(ifc.rresp), 64'(eresp));
    for (int k = 0; k < stall; k++) begin
      step();
      chk("rvalid_hold", 64'(ifc.rvalid), 64'(1));
      chk("rdata_hold", 64'(ifc.rdata), 64'(edata));
      chk("arready_busy", 64'(ifc.arready), 64'(0));
    end
    ifc.rready = 1'b1;
    step();
    ifc.rready = 1'b0;
    chk("rvalid_drop", 64'(ifc.rvalid), 64'(0));
    chk("arready_back", 64'(ifc.arready), 64'(1));
  endtask

  initial begin
    logic [5:0] ridx;
    logic [7:0] raddr;
    ifc.awaddr = '0; ifc.awprot = '0; ifc.awvalid = 1'b0;
    ifc.wdata  = '0; ifc.wstrb  = '0; ifc.wvalid  = 1'b0;
    ifc.bready = 1'b0;
    ifc.araddr = '0; ifc.arprot = '0; ifc.arvalid = 1'b0;
    ifc.rready = 1'b0;
    for (int i = 0; i < int'(NRW); i++) ctrl_m[i] = 32'd0;
    for (int i = 0; i < int'(NRO); i++) status_m[i] = 32'd0;

    // Reset values, then readies one edge after release.
    repeat (2) step();
    chk("rst_awready", 64'(ifc.awready), 64'(0));
    chk("rst_wready", 64'(ifc.wready), 64'(0));
    chk("rst_arready", 64'(ifc.arready), 64'(0));
    chk("rst_bvalid", 64'(ifc.bvalid), 64'(0));
    chk("rst_rvalid", 64'(ifc.rvalid), 64'(0));
    chk("rst_bresp", 64'(ifc.bresp), 64'(0));
    chk("rst_rresp", 64'(ifc.rresp), 64'(0));
    chk("rst_rdata", 64'(ifc.rdata), 64'(0));
    chk("rst_ctrl_wr", 64'(ctrl_wr), 64'(0));
    check_regs("rst_ctrl_q");
    rst = 1'b0;
    step();
    chk("post_rst_awready", 64'(ifc.awready), 64'(1));
    chk("post_rst_wready", 64'(ifc.wready), 64'(1));
    chk("post_rst_arready", 64'(ifc.arready), 64'(1));

    // Full write and readback, then byte-strobe merge.
    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(8'h04, 0);
    do_write(8'h04, 32'h11223344, 4'h5, 0, 1);
    chk("strobe_merge", 64'(ctrl_q[1*DW +: DW]), 64'(32'hDE22BE44));

    // W three cycles ahead of AW.
    do_write(8'h00, 32'h000000A5, 4'hF, 3, 0);
    chk("skew_reg0", 64'(ctrl_q[0 +: DW]), 64'(32'hA5));

    // Status read and illegal accesses.
    status_m[0] = 32'h12345678;
    status_m[1] = 32'hCAFEF00D;
    do_read(8'h18, 0);
    do_write(8'h18, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_read(8'h40, 0);
    do_read(8'h1C, 2);

    // Read backpressure, then AR colliding with a write commit to the same register.
    do_read(8'h00, 5);
    ifc.awaddr = 8'h00; ifc.wdata = 32'h55; ifc.wstrb = 4'hF; ifc.araddr = 8'h00;
    ifc.awvalid = 1'b1; ifc.wvalid = 1'b1; ifc.arvalid = 1'b1;
    step();
    ifc.awvalid = 1'b0; ifc.wvalid = 1'b0; ifc.arvalid = 1'b0;
    chk("coll_rvalid", 64'(ifc.rvalid), 64'(1));
    chk("coll_rdata_old", 64'(ifc.rdata), 64'(ctrl_m[0]));
    chk("coll_bvalid", 64'(ifc.bvalid), 64'(1));
    chk("coll_ctrl_wr", 64'(ctrl_wr), 64'(1));
    ctrl_m[0] = 32'h55;
    ifc.bready = 1'b1; ifc.rready = 1'b1;
    step();
    ifc.bready = 1'b0; ifc.rready = 1'b0;
    chk("coll_bvalid_drop", 64'(ifc.bvalid), 64'(0));
    chk("coll_rvalid_drop", 64'(ifc.rvalid), 64'(0));
    do_read(8'h00, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) ridx = 6'($urandom_range(0, 63));
      else                          ridx = 6'($urandom_range(0, 9));
      raddr = {ridx, 2'($urandom_range(0, 3))};
      case ($urandom_range(0, 2))
        0: do_write(raddr, $urandom, 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
        1: do_read(raddr, int'($urandom_range(0, 3)));
        default: status_m[$urandom_range(0, NRO - 1)] = $urandom;
      endcase
    end

    // Reset with both responses pending.
    ifc.awaddr = 8'h08; ifc.wdata = 32'h77; ifc.wstrb = 4'hF; ifc.araddr = 8'h08;
    ifc.awvalid = 1'b1; ifc.wvalid = 1'b1; ifc.arvalid = 1'b1;
    step();
    ifc.awvalid = 1'b0; ifc.wvalid = 1'b0; ifc.arvalid = 1'b0;
    chk("pre_rst_bvalid", 64'(ifc.bvalid), 64'(1));
    chk("pre_rst_rvalid", 64'(ifc.rvalid), 64'(1));
    rst = 1'b1;
    #1;
    for (int i = 0; i < int'(NRW); i++) ctrl_m[i] = 32'd0;
    chk("mid_rst_bvalid", 64'(ifc.bvalid), 64'(0));
    chk("mid_rst_rvalid", 64'(ifc.rvalid), 64'(0));
    chk("mid_rst_awready", 64'(ifc.awready), 64'(0));
    check_regs("mid_rst_ctrl_q");
    step();
    rst = 1'b0;
    step();
    chk("rel_awready", 64'(ifc.awready), 64'(1));
    chk("rel_wready", 64'(ifc.wready), 64'(1));
    chk("rel_arready", 64'(ifc.arready), 64'(1));
    do_read(8'h08, 0);
    do_write(8'h14, 32'h0BADF00D, 4'hC, -2, 1);
    do_read(8'h14, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
